// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared sizes and group-result record for the 256-to-8 encoder
package enc_pkg;
    localparam int NGRP   = 16;
    localparam int GRP_W  = 16;
    localparam int CODE_W = 8;

    typedef struct packed {
        logic       any;
        logic       multi;
        logic [3:0] idx;
    } grp_t;
endpackage

// File: rtl/enc_grp16.sv
// rtl/enc_grp16.sv - combinational 16-bit low-priority encoder with any/multi flags
module enc_grp16
    import enc_pkg::*;
(
    input  logic [GRP_W-1:0] v,
    output logic             any,
    output logic             multi,
    output logic [3:0]       idx
);
    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = GRP_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
    end

    assign any   = |v;
    // Clearing the lowest set bit leaves something only when two or more were set.
    assign multi = |(v & (v - GRP_W'(1)));
endmodule

// File: rtl/enc.sv
// rtl/enc.sv - two-stage pipelined 256-to-8 priority encoder with valid/ready handshake
module enc #(
    parameter int NGRP = enc_pkg::NGRP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] selectp2,
    input  logic [127:0] selectp1,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   count,
    output logic         zero,
    output logic         multi,
    output logic         out_valid,
    input  logic         out_ready
);
    import enc_pkg::grp_t;
    import enc_pkg::GRP_W;
    import enc_pkg::CODE_W;

    logic [NGRP*GRP_W-1:0] v;
    logic [NGRP-1:0]       g_any;
    logic [NGRP-1:0]       g_multi;
    logic [3:0]            g_idx [NGRP];

    grp_t                  s1_grp [NGRP];
    logic                  s1_valid;
    logic                  s1_adv;
    logic                  s2_adv;

    logic [CODE_W-1:0]     cnt_n;
    logic                  found_n;
    logic                  multi_n;

    assign v        = {selectp1, selectp2};
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        enc_grp16 u_grp (
            .v     (v[g*GRP_W +: GRP_W]),
            .any   (g_any[g]),
            .multi (g_multi[g]),
            .idx   (g_idx[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int g = 0; g < NGRP; g++) s1_grp[g] <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int g = 0; g < NGRP; g++) begin
                    s1_grp[g] <= '{any: g_any[g], multi: g_multi[g], idx: g_idx[g]};
                end
            end
        end
    end

    // Lowest occupied group supplies the code; a second occupied group means multi.
    always_comb begin
        cnt_n   = '0;
        found_n = 1'b0;
        multi_n = 1'b0;
        for (int g = 0; g < NGRP; g++) begin
            if (s1_grp[g].multi) multi_n = 1'b1;
            if (s1_grp[g].any) begin
                if (found_n) begin
                    multi_n = 1'b1;
                end else begin
                    found_n = 1'b1;
                    cnt_n   = {4'(g), s1_grp[g].idx};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            count     <= '0;
            zero      <= 1'b0;
            multi     <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                count <= cnt_n;
                zero  <= !found_n;
                multi <= multi_n;
            end
        end
    end
endmodule

// File: tb/tb_enc.sv
// tb/tb_enc.sv - self-checking bench for enc
module tb_enc;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] selectp2;
    logic [127:0] selectp1;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   count;
    logic         zero;
    logic         multi;
    logic         out_valid;
    logic         out_ready;

    always #5 clk = ~clk;

    enc dut (
        .clk       (clk),
        .rst       (rst),
        .selectp2  (selectp2),
        .selectp1  (selectp1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .count     (count),
        .zero      (zero),
        .multi     (multi),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [255:0] v;
        logic [7:0]   cnt;
        logic         zero;
        logic         multi;
    } vec_t;

    vec_t        tbl [10];
    logic [9:0]  expq [$];
    int          cycq [$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    bit          lat_on = 0;
    bit          hold_pend = 0;
    logic [10:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [255:0] bits2(input int a, input int b);
        logic [255:0] r = '0;
        r[a] = 1'b1;
        r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [9:0] model(input logic [255:0] vv);
        logic [7:0] c = '0;
        int pc = 0;
        for (int k = 255; k >= 0; k--) begin
            if (vv[k]) begin
                c = 8'(k);
                pc++;
            end
        end
        return {c, pc == 0, pc >= 2};
    endfunction

    // One handshake cycle: drive after the falling edge, evaluate handshakes before the rising edge.
    task automatic step(input logic iv, input logic [255:0] vv, input logic ordy,
                        input logic [9:0] exp, output logic acc);
        @(negedge clk);
        cyc++;
        if (hold_pend) chk("hold", {out_valid, count, zero, multi}, held);
        in_valid = iv;
        {selectp1, selectp2} = vv;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got count %0h with no pending input", count);
            end else begin
                logic [9:0] e;
                int c0;
                e  = expq.pop_front();
                c0 = cycq.pop_front();
                chk("result", {count, zero, multi}, e);
                if (lat_on) chk("latency", cyc - c0, 2);
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            expq.push_back(exp);
            cycq.push_back(cyc);
        end
        hold_pend = out_valid && !out_ready;
        held = {out_valid, count, zero, multi};
    endtask

    task automatic drain(input string name);
        logic acc;
        for (int i = 0; i < 20 && expq.size() != 0; i++) step(1'b0, '0, 1'b1, '0, acc);
        chk(name, expq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic         acc;
        logic [255:0] vv;
        logic [255:0] bp [3];
        int           sent;
        logic         iv;

        tbl[0] = '{'0,            8'd0,   1'b1, 1'b0};
        tbl[1] = '{bits2(5, 131), 8'd5,   1'b0, 1'b1};
        tbl[2] = '{bits2(20, 17), 8'd17,  1'b0, 1'b1};
        tbl[3] = '{bits2(255, 255), 8'd255, 1'b0, 1'b0};
        tbl[4] = '{bits2(0, 0),   8'd0,   1'b0, 1'b0};
        tbl[5] = '{bits2(16, 255), 8'd16, 1'b0, 1'b1};
        tbl[6] = '{bits2(14, 15), 8'd14,  1'b0, 1'b1};
        tbl[7] = '{bits2(128, 127), 8'd127, 1'b0, 1'b1};
        tbl[8] = '{bits2(128, 128), 8'd128, 1'b0, 1'b0};
        tbl[9] = '{'1,            8'd0,   1'b0, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        selectp1 = '0;
        selectp2 = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {count, zero, multi}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].v, 1'b1, {tbl[i].cnt, tbl[i].zero, tbl[i].multi}, acc);
            chk("tbl_accept", acc, 1);
        end
        drain("tbl_drain");

        lat_on = 1;
        for (int k = 0; k < 256; k++) begin
            step(1'b1, bits2(k, k), 1'b1, {8'(k), 2'b00}, acc);
            if (!acc) chk("onehot_accept", acc, 1);
        end
        drain("onehot_drain");
        lat_on = 0;

        bp[0] = bits2(200, 200);
        bp[1] = bits2(7, 7);
        bp[2] = bits2(77, 90);
        step(1'b1, bp[0], 1'b0, model(bp[0]), acc);
        chk("bp_acc0", acc, 1);
        step(1'b1, bp[1], 1'b0, model(bp[1]), acc);
        chk("bp_acc1", acc, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, bp[2], 1'b0, model(bp[2]), acc);
            chk("bp_in_ready_low", acc, 0);
        end
        step(1'b1, bp[2], 1'b1, model(bp[2]), acc);
        chk("bp_acc2", acc, 1);
        drain("bp_drain");

        step(1'b1, bits2(33, 33), 1'b0, model(bits2(33, 33)), acc);
        step(1'b1, bits2(99, 99), 1'b0, model(bits2(99, 99)), acc);
        @(negedge clk);
        in_valid = 1'b1;
        {selectp1, selectp2} = bits2(3, 3);
        rst = 1'b1;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_in_ready", in_ready, 1);
        expq.delete();
        cycq.delete();
        hold_pend = 0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, '0, acc);
        chk("rstmid_no_stale", out_valid, 0);
        step(1'b1, bits2(42, 42), 1'b1, {8'd42, 2'b00}, acc);
        chk("rstmid_accept", acc, 1);
        drain("rstmid_drain");

        sent = 0;
        acc = 1'b1;
        iv = 1'b0;
        vv = '0;
        for (int c = 0; c < 40000 && sent < 10000; c++) begin
            if (!(iv && !acc)) begin
                iv = ($urandom_range(0, 3) != 0);
                vv = '0;
                case ($urandom_range(0, 3))
                    0: vv = '0;
                    1: vv = bits2($urandom_range(0, 255), $urandom_range(0, 255)) & bits2(255, 255) ? bits2(255, 255) : bits2(0, 0);
                    2: vv = bits2($urandom_range(0, 255), $urandom_range(0, 255));
                    default: for (int j = 0; j < 8; j++) vv[j*32 +: 32] = $urandom;
                endcase
                if (vv == bits2(0, 0)) vv = bits2($urandom_range(0, 255), 0) ^ bits2(0, 0);
            end
            step(iv, vv, ($urandom_range(0, 3) != 0), model(vv), acc);
            if (acc) sent++;
        end
        chk("rand_sent", sent, 10000);
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
